// File: rtl/park_pkg.sv
// Shared definitions for the parking-lot entry and exit paths.
// Holds the spot count, the entry FSM state type, and the token cipher.
// The cipher XORs the park number with a per-car pattern, then rotates the
// result left by one bit. The exit path undoes it with decrypt_token.
package park_pkg;

    localparam int unsigned NUM_SPOTS = 8;
    localparam int unsigned SPOT_W    = 3;
    localparam int unsigned COUNT_W   = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAlloc = 2'd1,
        StIssue = 2'd2
    } entry_state_e;

    function automatic logic [SPOT_W-1:0] encrypt_token(input logic [SPOT_W-1:0] park_number,
                                                        input logic [SPOT_W-1:0] pattern);
        logic [SPOT_W-1:0] p;
        p = park_number ^ pattern;
        return {p[1:0], p[2]};
    endfunction

    function automatic logic [SPOT_W-1:0] decrypt_token(input logic [SPOT_W-1:0] token,
                                                        input logic [SPOT_W-1:0] pattern);
        logic [SPOT_W-1:0] p;
        p = {token[0], token[2:1]};
        return p ^ pattern;
    endfunction

endpackage

// File: rtl/encrypt.sv
// Combinational token encryption; the entry-side twin of the exit path's decrypt.
// Ports:
//   park_number  allocated spot number
//   pattern      per-car encryption pattern
//   token        encrypted park number
module encrypt
    import park_pkg::*;
(
    input  logic [SPOT_W-1:0] park_number,
    input  logic [SPOT_W-1:0] pattern,
    output logic [SPOT_W-1:0] token
);

    assign token = encrypt_token(park_number, pattern);

endmodule

// File: rtl/entry_park.sv
// Entry side of the parking lot. Tracks the 8-spot occupancy map, allocates
// the lowest free spot to each arriving car and hands out an encrypted token
// through a valid/ack handshake. Exits (one-hot park_location) free spots in
// any FSM state.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   entry_req       car at the gate (level), sampled in IDLE
//   pattern         per-car pattern, latched on request acceptance
//   token           encrypted park number, stable while token_valid
//   token_valid     token available
//   token_ack       token taken by the gate
//   entry_reject    one-cycle pulse, request seen while the lot was full
//   exit            exit strobe qualifying park_location
//   park_location   one-hot spot being vacated
//   exit_error      one-cycle pulse for an invalid exit
//   occupancy       bit i set when spot i is taken
//   free_count      number of free spots, 0..8
//   full            no free spots
module entry_park
    import park_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 entry_req,
    input  logic [SPOT_W-1:0]    pattern,
    output logic [SPOT_W-1:0]    token,
    output logic                 token_valid,
    input  logic                 token_ack,
    output logic                 entry_reject,
    input  logic                 exit,
    input  logic [NUM_SPOTS-1:0] park_location,
    output logic                 exit_error,
    output logic [NUM_SPOTS-1:0] occupancy,
    output logic [COUNT_W-1:0]   free_count,
    output logic                 full
);

    entry_state_e         state_q, state_d;
    logic [SPOT_W-1:0]    pattern_q, pattern_d;
    logic [SPOT_W-1:0]    token_q, token_d;
    logic [NUM_SPOTS-1:0] occupancy_q, occupancy_d;
    logic [COUNT_W-1:0]   free_count_q, free_count_d;
    logic                 entry_reject_q, entry_reject_d;
    logic                 exit_error_q, exit_error_d;

    logic                 alloc_found;
    logic [SPOT_W-1:0]    alloc_idx;
    logic                 do_alloc;
    logic                 loc_one_hot;
    logic                 exit_valid;
    logic [SPOT_W-1:0]    enc_token;

    // Lowest clear bit of the pre-exit map; a spot freed this cycle is not
    // eligible until the next one.
    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
            if (!occupancy_q[i]) begin
                alloc_found = 1'b1;
                alloc_idx   = SPOT_W'(i);
            end
        end
    end

    assign loc_one_hot = (park_location != '0) &&
                         ((park_location & (park_location - NUM_SPOTS'(1))) == '0);
    assign exit_valid  = exit && loc_one_hot && ((park_location & occupancy_q) != '0);
    assign do_alloc    = (state_q == StAlloc) && alloc_found;

    encrypt u_encrypt (
        .park_number (alloc_idx),
        .pattern     (pattern_q),
        .token       (enc_token)
    );

    always_comb begin
        state_d        = state_q;
        pattern_d      = pattern_q;
        token_d        = token_q;
        entry_reject_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (entry_req) begin
                    if (free_count_q == '0) begin
                        entry_reject_d = 1'b1;
                    end else begin
                        pattern_d = pattern;
                        state_d   = StAlloc;
                    end
                end
            end
            StAlloc: begin
                token_d = enc_token;
                state_d = StIssue;
            end
            StIssue: begin
                if (token_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Allocation and exit touch different bits, so both commit together.
    always_comb begin
        occupancy_d  = occupancy_q;
        free_count_d = free_count_q;
        exit_error_d = exit && !exit_valid;
        if (do_alloc) begin
            occupancy_d[alloc_idx] = 1'b1;
            free_count_d           = free_count_d - COUNT_W'(1);
        end
        if (exit_valid) begin
            occupancy_d  = occupancy_d & ~park_location;
            free_count_d = free_count_d + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            pattern_q      <= '0;
            token_q        <= '0;
            occupancy_q    <= '0;
            free_count_q   <= COUNT_W'(NUM_SPOTS);
            entry_reject_q <= 1'b0;
            exit_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pattern_q      <= pattern_d;
            token_q        <= token_d;
            occupancy_q    <= occupancy_d;
            free_count_q   <= free_count_d;
            entry_reject_q <= entry_reject_d;
            exit_error_q   <= exit_error_d;
        end
    end

    assign token        = token_q;
    assign token_valid  = (state_q == StIssue);
    assign entry_reject = entry_reject_q;
    assign exit_error   = exit_error_q;
    assign occupancy    = occupancy_q;
    assign free_count   = free_count_q;
    assign full         = (free_count_q == '0);

endmodule

// File: tb/tb_entry_park.sv
module tb_entry_park;

    logic       clk;
    logic       rst_n;
    logic       entry_req;
    logic [2:0] pattern;
    logic [2:0] token;
    logic       token_valid;
    logic       token_ack;
    logic       entry_reject;
    logic       exit;
    logic [7:0] park_location;
    logic       exit_error;
    logic [7:0] occupancy;
    logic [3:0] free_count;
    logic       full;

    entry_park dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .entry_req     (entry_req),
        .pattern       (pattern),
        .token         (token),
        .token_valid   (token_valid),
        .token_ack     (token_ack),
        .entry_reject  (entry_reject),
        .exit          (exit),
        .park_location (park_location),
        .exit_error    (exit_error),
        .occupancy     (occupancy),
        .free_count    (free_count),
        .full          (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] KTok = 2'd0;
    localparam logic [1:0] KRej = 2'd1;
    localparam logic [1:0] KErr = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] value;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents an output event.
    logic tv_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (token_valid && !tv_prev) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL token_unexpected: got %0h expected none", token);
            end else begin
                e = sb.pop_front();
                check("token_kind", int'(KTok), int'(e.kind));
                check("token", int'(token), int'(e.value));
            end
        end
        if (entry_reject) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL reject_unexpected: got 1 expected none");
            end else begin
                e = sb.pop_front();
                check("reject_kind", int'(KRej), int'(e.kind));
            end
        end
        if (exit_error) begin
            if (sb.size() == 0) begin
                total++; bad++;
                $display("FAIL exit_error_unexpected: got 1 expected none");
            end else begin
                e = sb.pop_front();
                check("exit_error_kind", int'(KErr), int'(e.kind));
            end
        end
        tv_prev <= token_valid;
    end

    task automatic wait_valid();
        bit got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (token_valid) got = 1'b1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL token_timeout: token_valid got 0 expected 1");
        end
    endtask

    task automatic ack_token();
        token_ack = 1'b1;
        @(posedge clk); #1;
        token_ack = 1'b0;
    endtask

    task automatic do_entry(input logic [2:0] pat, input logic [2:0] exp_tok, input bit ack);
        sb.push_back('{kind: KTok, value: exp_tok});
        entry_req = 1'b1;
        pattern   = pat;
        @(posedge clk); #1;
        entry_req = 1'b0;
        wait_valid();
        if (ack) ack_token();
    endtask

    task automatic do_exit(input logic [7:0] loc, input bit err);
        if (err) sb.push_back('{kind: KErr, value: 3'd0});
        exit          = 1'b1;
        park_location = loc;
        @(posedge clk); #1;
        exit          = 1'b0;
        park_location = 8'h00;
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_occupancy", int'(occupancy), 8'h00);
        check("rst_free_count", int'(free_count), 8);
        check("rst_token_valid", int'(token_valid), 0);
        check("rst_full", int'(full), 0);
        check("rst_token", int'(token), 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Spots 1..7 with pattern 000: token = rotl(n).
    logic [2:0] fill_tok [1:7] = '{3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};

    initial begin
        rst_n         = 1'b0;
        entry_req     = 1'b0;
        pattern       = 3'b000;
        token_ack     = 1'b0;
        exit          = 1'b0;
        park_location = 8'h00;
        #12;
        check("init_occupancy", int'(occupancy), 8'h00);
        check("init_free_count", int'(free_count), 8);
        check("init_token_valid", int'(token_valid), 0);
        check("init_reject", int'(entry_reject), 0);
        check("init_exit_error", int'(exit_error), 0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;

        // First entry: spot 0, pattern 101 -> p=101 -> token 011.
        do_entry(3'b101, 3'b011, 1'b0);
        check("first_occupancy", int'(occupancy), 8'h01);
        check("first_free_count", int'(free_count), 7);
        ack_token();
        @(negedge clk);
        check("first_idle_valid", int'(token_valid), 0);

        // Fill the lot.
        for (int n = 1; n <= 7; n++) do_entry(3'b000, fill_tok[n], 1'b1);
        @(negedge clk);
        check("fill_occupancy", int'(occupancy), 8'hFF);
        check("fill_free_count", int'(free_count), 0);
        check("fill_full", int'(full), 1);

        // Ninth request is rejected with no state change.
        sb.push_back('{kind: KRej, value: 3'd0});
        entry_req = 1'b1;
        @(posedge clk); #1;
        entry_req = 1'b0;
        @(negedge clk); #1;
        check("reject_occupancy", int'(occupancy), 8'hFF);
        check("reject_valid", int'(token_valid), 0);
        @(negedge clk);
        check("reject_one_pulse", int'(entry_reject), 0);

        // Free spot 3 then reuse it: pattern 000 -> token 110.
        do_exit(8'h08, 1'b0);
        check("exit_occupancy", int'(occupancy), 8'hF7);
        check("exit_free_count", int'(free_count), 1);
        check("exit_full", int'(full), 0);
        do_entry(3'b000, 3'b110, 1'b1);
        @(negedge clk);
        check("reuse_occupancy", int'(occupancy), 8'hFF);

        // Invalid exits.
        do_exit(8'h03, 1'b1);
        check("multi_hot_occupancy", int'(occupancy), 8'hFF);
        do_exit(8'h40, 1'b0);
        check("exit6_occupancy", int'(occupancy), 8'hBF);
        do_exit(8'h40, 1'b1);
        check("free_spot_occupancy", int'(occupancy), 8'hBF);
        check("free_spot_count", int'(free_count), 1);
        do_exit(8'h00, 1'b1);
        check("zero_loc_occupancy", int'(occupancy), 8'hBF);

        // Exit in the ALLOC cycle: occ=01, exit spot 0, spot 1 allocated.
        do_reset();
        do_entry(3'b000, 3'b000, 1'b1);
        sb.push_back('{kind: KTok, value: 3'b110}); // n=1 ^ 010 = 011 -> 110
        entry_req = 1'b1;
        pattern   = 3'b010;
        @(posedge clk); #1;
        entry_req     = 1'b0;
        exit          = 1'b1;
        park_location = 8'h01;
        @(posedge clk); #1;
        exit          = 1'b0;
        park_location = 8'h00;
        wait_valid();
        check("alloc_exit_occupancy", int'(occupancy), 8'h02);
        check("alloc_exit_free_count", int'(free_count), 7);
        ack_token();

        // Reset during ISSUE: spot 0 taken, then reset releases it.
        do_entry(3'b000, 3'b000, 1'b0);
        check("pre_reset_occupancy", int'(occupancy), 8'h03);
        check("pre_reset_valid", int'(token_valid), 1);
        do_reset();
        check("post_reset_occupancy", int'(occupancy), 8'h00);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
